apb_irq_ctrl: RTL and testbench
===============================

APB_IRQ_CTRL -- requirements
Module: apb_irq_ctrl

Interface
REQ-001 SHALL have parameter NSRC, default 16, number of interrupt sources (legal range 1..31).
REQ-002 SHALL have port PCLK, input, 1, the only clock.
REQ-003 SHALL have port PRESETn, input, 1, asynchronous active-low reset.
REQ-004 SHALL have APB slave ports PSEL, PENABLE, PWRITE (in, 1 each), PADDR (in, 4), PSTRB (in, 4), PWDATA (in, 32), PRDATA (out, 32), PREADY (out, 1), PSLVERR (out, 1).
REQ-005 SHALL have port irq_src_i, input, NSRC, level interrupt requests from GPIO irq_o lines and peer peripherals.
REQ-006 SHALL have port irq_o, output, 1, registered interrupt to the CPU.

Function
REQ-007 SHALL tie PREADY=1 and PSLVERR=0, giving zero-wait-state access.
REQ-008 SHALL use this word map (PADDR): 0 ENABLE RW; 1 EDGE RW (0 = level, 1 = rising edge); 2 PENDING RO/W1C; 3 CLAIM; 4 STATUS RO. All other addresses read 0 and ignore writes.
REQ-009 SHALL apply writes to ENABLE and EDGE per PSTRB byte lane; bits at or above NSRC read 0.
REQ-010 SHALL register PRDATA on every PCLK edge from the PADDR decode, so read data is valid in the access phase.
REQ-011 SHALL derive a sampled vector s from irq_src_i (see REQ-022) and a delayed copy s_d.
REQ-012 SHALL make PENDING[n] a live copy of s[n] when EDGE[n]=0, and sticky-set on s[n]&~s_d[n] when EDGE[n]=1.
REQ-013 SHALL clear edge PENDING bits on a W1C write (lane-gated by PSTRB); W1C SHALL have no effect on level bits. If set and clear occur in the same cycle, set wins.
REQ-014 SHALL implement claim FSM states IDLE and BUSY.
REQ-015 SHALL, on a CLAIM read setup phase, capture claim_id = 1 + index of the lowest-numbered bit of PENDING&ENABLE, or 0 if none; in BUSY, claim_id SHALL be 0. PRDATA[4:0] SHALL return claim_id.
REQ-016 SHALL, on a CLAIM read access phase with claim_id≠0 in IDLE, go to BUSY, latch cur_id=claim_id, and clear PENDING[cur_id-1] if it is an edge source; set wins as in REQ-013.
REQ-017 SHALL, on a CLAIM write with PSTRB[0]=1 and PWDATA[4:0]==cur_id in BUSY, return to IDLE (complete); all other CLAIM writes SHALL be ignored.
REQ-018 SHALL make STATUS read as {19'b0, cur_id[4:0], 7'b0, busy}; cur_id SHALL be 0 in IDLE.
REQ-019 SHALL register irq_o = (state==IDLE) & |(PENDING&ENABLE).
REQ-020 SHALL give latency from an irq_src_i rising edge (enabled, IDLE) to irq_o=1 of 4 PCLK edges with IRQ_CTRL_SYNC_EN and 2 without.

Reset
REQ-021 SHALL, on PRESETn low, immediately clear ENABLE, EDGE, PENDING, s, s_d, cur_id and irq_o to 0, and set state to IDLE; PRDATA SHALL reset to 0. A reset while BUSY SHALL abandon the claim.

Configuration
REQ-022 SHALL, with IRQ_CTRL_SYNC_EN defined, form s through a two-flop synchroniser on irq_src_i; without the macro, s SHALL be a single register stage sampling irq_src_i, for synchronous sources only.

Structure
REQ-023 SHALL place the register address constants, the state enum (IDLE/BUSY) and the ID width constant (5) in package apb_irq_ctrl_pkg.
REQ-024 SHALL implement the lowest-index-wins search of REQ-015 in sub-module irq_prio_enc (NSRC in, found flag and index out, combinational).

Verification
REQ-025 SHALL test level-source routing: ENABLE=0x0001, EDGE=0, irq_src_i[0] 0→1 -> irq_o=1 after 4 edges (SYNC_EN); CLAIM read=1; irq_o=0 while BUSY; write CLAIM=1 -> IDLE, irq_o=1 again while the source is held.
REQ-026 SHALL test edge priority: EDGE=ENABLE=0x0030, pulse src 4 and src 5 together -> PENDING=0x30; CLAIM reads 5, then complete 5; next CLAIM reads 6.
REQ-027 SHALL test W1C and collision: edge src 2 pending, write PENDING=0x4 in the same cycle a new s rising edge arrives -> PENDING[2] stays 1; with no collision it clears to 0.
REQ-028 SHALL test protocol errors: in BUSY with cur_id=3, write CLAIM=2 -> stays BUSY, STATUS=0x0301; CLAIM read in BUSY returns 0; a write with PSTRB=0 is ignored.
REQ-029 SHALL test reset mid-claim: assert PRESETn low in BUSY -> irq_o, STATUS and all registers read 0 after release; unmapped address 0xF reads 0.

Source files
------------

// File: rtl/apb_irq_ctrl_pkg.sv
// Shared constants for apb_irq_ctrl: register word addresses, claim FSM states, source ID width.
package apb_irq_ctrl_pkg;

    localparam int unsigned IdWidth = 5;

    localparam logic [3:0] AddrEnable  = 4'd0;
    localparam logic [3:0] AddrEdge    = 4'd1;
    localparam logic [3:0] AddrPending = 4'd2;
    localparam logic [3:0] AddrClaim   = 4'd3;
    localparam logic [3:0] AddrStatus  = 4'd4;

    typedef enum logic {
        StIdle = 1'b0,
        StBusy = 1'b1
    } claim_state_e;

    // Expand PSTRB into a per-bit write mask.
    function automatic logic [31:0] lane_mask(input logic [3:0] strb);
        return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational lowest-index-wins search over the request vector.
module irq_prio_enc
    import apb_irq_ctrl_pkg::*;
#(
    parameter int unsigned NSRC = 16
) (
    input  logic [NSRC-1:0]    req_i,
    output logic               found_o,
    output logic [IdWidth-1:0] idx_o
);

    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        // Scan downwards so the lowest set bit is the last one written.
        for (int i = int'(NSRC) - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                found_o = 1'b1;
                idx_o   = IdWidth'(i);
            end
        end
    end

endmodule

// File: rtl/apb_irq_ctrl.sv
// APB interrupt controller: ENABLE/EDGE/PENDING registers and a lowest-ID claim/complete handshake.
// Define IRQ_CTRL_SYNC_EN to put a two-flop synchroniser ahead of the source sampling stage.
module apb_irq_ctrl
    import apb_irq_ctrl_pkg::*;
#(
    parameter int unsigned NSRC = 16
) (
    input  logic            PCLK,
    input  logic            PRESETn,
    input  logic            PSEL,
    input  logic            PENABLE,
    input  logic            PWRITE,
    input  logic [3:0]      PADDR,
    input  logic [3:0]      PSTRB,
    input  logic [31:0]     PWDATA,
    output logic [31:0]     PRDATA,
    output logic            PREADY,
    output logic            PSLVERR,
    input  logic [NSRC-1:0] irq_src_i,
    output logic            irq_o
);

    claim_state_e       state_q, state_d;
    logic [NSRC-1:0]    enable_q, enable_d, trig_q, trig_d, pending_q, pending_d;
    logic [NSRC-1:0]    s_q, s_d, s_dly_q, s_dly_d, s_in;
    logic [IdWidth-1:0] cur_id_q, cur_id_d, claim_id_q, claim_id_d, claim_cand;
    logic               irq_q, irq_d;
    logic [31:0]        prdata_q, prdata_d, lane_full;
    logic [NSRC-1:0]    lane, wdata, pend_en, set_edge, clr_edge;
    logic               found, access, wr_access;
    logic [IdWidth-1:0] found_idx;
    logic               unused_bits;

    assign PREADY      = 1'b1;
    assign PSLVERR     = 1'b0;
    assign PRDATA      = prdata_q;
    assign irq_o       = irq_q;
    assign access      = PSEL & PENABLE;
    assign wr_access   = access & PWRITE;
    assign lane_full   = lane_mask(PSTRB);
    assign lane        = lane_full[NSRC-1:0];
    assign wdata       = PWDATA[NSRC-1:0];
    assign pend_en     = pending_q & enable_q;
    assign unused_bits = ^{PWDATA[31:NSRC], lane_full[31:NSRC]};

`ifdef IRQ_CTRL_SYNC_EN
    logic [NSRC-1:0] meta_q, sync_q;
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= irq_src_i;
            sync_q <= meta_q;
        end
    end
    assign s_in = sync_q;
`else
    assign s_in = irq_src_i;
`endif

    irq_prio_enc #(
        .NSRC (NSRC)
    ) u_prio_enc (
        .req_i   (pend_en),
        .found_o (found),
        .idx_o   (found_idx)
    );

    always_comb begin
        enable_d   = enable_q;
        trig_d     = trig_q;
        state_d    = state_q;
        cur_id_d   = cur_id_q;
        claim_id_d = claim_id_q;
        s_d        = s_in;
        s_dly_d    = s_q;
        clr_edge   = '0;
        set_edge   = s_q & ~s_dly_q & trig_q;
        claim_cand = (state_q == StIdle && found) ? found_idx + IdWidth'(1) : '0;

        if (wr_access) begin
            case (PADDR)
                AddrEnable:  enable_d = (enable_q & ~lane) | (wdata & lane);
                AddrEdge:    trig_d   = (trig_q & ~lane) | (wdata & lane);
                AddrPending: clr_edge = wdata & lane & trig_q;
                AddrClaim: begin
                    if (state_q == StBusy && PSTRB[0] && PWDATA[IdWidth-1:0] == cur_id_q) begin
                        state_d  = StIdle;
                        cur_id_d = '0;
                    end
                end
                default: ;
            endcase
        end

        if (PSEL && !PENABLE && !PWRITE && PADDR == AddrClaim) begin
            claim_id_d = claim_cand;
        end

        // The ID was fixed in the setup phase; the access phase commits the claim.
        if (access && !PWRITE && PADDR == AddrClaim && state_q == StIdle && claim_id_q != '0) begin
            state_d  = StBusy;
            cur_id_d = claim_id_q;
            clr_edge = clr_edge | (trig_q & (NSRC'(1) << (claim_id_q - IdWidth'(1))));
        end

        // A new edge on the same cycle as a clear keeps the bit set.
        pending_d = (trig_q & ((pending_q & ~clr_edge) | set_edge)) | (~trig_q & s_q);
        irq_d     = (state_d == StIdle) && (|(pending_d & enable_d));

        prdata_d = '0;
        case (PADDR)
            AddrEnable:  prdata_d[NSRC-1:0] = enable_q;
            AddrEdge:    prdata_d[NSRC-1:0] = trig_q;
            AddrPending: prdata_d[NSRC-1:0] = pending_q;
            AddrClaim:   prdata_d[IdWidth-1:0] = claim_cand;
            AddrStatus: begin
                prdata_d[8 +: IdWidth] = cur_id_q;
                prdata_d[0]            = (state_q == StBusy);
            end
            default: ;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q    <= StIdle;
            enable_q   <= '0;
            trig_q     <= '0;
            pending_q  <= '0;
            s_q        <= '0;
            s_dly_q    <= '0;
            cur_id_q   <= '0;
            claim_id_q <= '0;
            irq_q      <= 1'b0;
            prdata_q   <= '0;
        end else begin
            state_q    <= state_d;
            enable_q   <= enable_d;
            trig_q     <= trig_d;
            pending_q  <= pending_d;
            s_q        <= s_d;
            s_dly_q    <= s_dly_d;
            cur_id_q   <= cur_id_d;
            claim_id_q <= claim_id_d;
            irq_q      <= irq_d;
            prdata_q   <= prdata_d;
        end
    end

endmodule

// File: tb/tb_apb_irq_ctrl.sv
// Randomised and directed bench for apb_irq_ctrl against a cycle-level behavioural model.
module tb_apb_irq_ctrl;

    localparam int NSRC = 16;
`ifdef IRQ_CTRL_SYNC_EN
    localparam int Lat    = 3;
    localparam int IrqLat = 4;
`else
    localparam int Lat    = 1;
    localparam int IrqLat = 2;
`endif

    logic            pclk, prstn, psel, penable, pwrite;
    logic [3:0]      paddr, pstrb;
    logic [31:0]     pwdata, prdata;
    logic            pready, pslverr, irq_o;
    logic [NSRC-1:0] irq_src;

    apb_irq_ctrl #(
        .NSRC (NSRC)
    ) dut (
        .PCLK      (pclk),
        .PRESETn   (prstn),
        .PSEL      (psel),
        .PENABLE   (penable),
        .PWRITE    (pwrite),
        .PADDR     (paddr),
        .PSTRB     (pstrb),
        .PWDATA    (pwdata),
        .PRDATA    (prdata),
        .PREADY    (pready),
        .PSLVERR   (pslverr),
        .irq_src_i (irq_src),
        .irq_o     (irq_o)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model state
    logic [NSRC-1:0] m_en, m_trig, m_pend;
    logic [NSRC-1:0] sh [0:3];
    bit              m_busy, m_irq;
    int              m_cur, m_claim;
    logic [31:0]     m_prd;
    logic [31:0]     d;
    int unsigned     r;
    logic [3:0]      a;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int first_id(input logic [NSRC-1:0] v);
        for (int n = 0; n < NSRC; n++) if (v[n]) return n + 1;
        return 0;
    endfunction

    function automatic logic [NSRC-1:0] merge(input logic [NSRC-1:0] old, input logic [31:0] dat,
                                              input logic [3:0] st);
        logic [NSRC-1:0] res;
        res = old;
        for (int n = 0; n < NSRC; n++) if (st[n / 8]) res[n] = dat[n];
        return res;
    endfunction

    function automatic logic [31:0] model_rd(input logic [3:0] ad);
        case (ad)
            4'd0:    return 32'(m_en);
            4'd1:    return 32'(m_trig);
            4'd2:    return 32'(m_pend);
            4'd3:    return m_busy ? 32'd0 : 32'(first_id(m_pend & m_en));
            4'd4:    return 32'((m_cur << 8) | int'(m_busy));
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_en = '0; m_trig = '0; m_pend = '0; m_busy = 0; m_irq = 0;
        m_cur = 0; m_claim = 0; m_prd = '0;
        for (int i = 0; i < 4; i++) sh[i] = '0;
    endtask

    // One clock edge of the reference: pre-edge state plus current bus inputs give next state.
    task automatic model_step();
        logic [NSRC-1:0] s, sd, clr, en_n, tr_n, pend_n;
        logic [31:0]     prd_n;
        bit              busy_n;
        int              cur_n, claim_n;
        s = sh[Lat-1];
        sd = sh[Lat];
        en_n = m_en; tr_n = m_trig; busy_n = m_busy; cur_n = m_cur; claim_n = m_claim;
        clr = '0;
        prd_n = model_rd(paddr);
        if (psel && penable && pwrite) begin
            case (paddr)
                4'd0: en_n = merge(m_en, pwdata, pstrb);
                4'd1: tr_n = merge(m_trig, pwdata, pstrb);
                4'd2: clr = merge('0, pwdata, pstrb) & m_trig;
                4'd3: if (m_busy && pstrb[0] && pwdata[4:0] == 5'(m_cur)) begin
                    busy_n = 0;
                    cur_n  = 0;
                end
                default: ;
            endcase
        end
        if (psel && !penable && !pwrite && paddr == 4'd3)
            claim_n = m_busy ? 0 : first_id(m_pend & m_en);
        if (psel && penable && !pwrite && paddr == 4'd3 && !m_busy && m_claim != 0) begin
            busy_n = 1;
            cur_n  = m_claim;
            if (m_trig[m_claim-1]) clr[m_claim-1] = 1'b1;
        end
        for (int n = 0; n < NSRC; n++)
            pend_n[n] = m_trig[n] ? ((m_pend[n] && !clr[n]) || (s[n] && !sd[n])) : s[n];
        for (int i = 3; i > 0; i--) sh[i] = sh[i-1];
        sh[0] = irq_src;
        m_en = en_n; m_trig = tr_n; m_pend = pend_n; m_busy = busy_n; m_cur = cur_n;
        m_claim = claim_n; m_prd = prd_n;
        m_irq = !busy_n && (|(pend_n & en_n));
    endtask

    task automatic cyc();
        @(posedge pclk);
        model_step();
        #1;
        check_eq("irq_o", 32'(irq_o), 32'(m_irq));
        check_eq("prdata", prdata, m_prd);
        check_eq("pready", 32'(pready), 32'd1);
        check_eq("pslverr", 32'(pslverr), 32'd0);
    endtask

    task automatic apb_write(input logic [3:0] ad, input logic [31:0] dat, input logic [3:0] st);
        psel = 1; penable = 0; pwrite = 1; paddr = ad; pwdata = dat; pstrb = st;
        cyc();
        penable = 1;
        cyc();
        psel = 0; penable = 0; pwrite = 0;
    endtask

    task automatic apb_read(input logic [3:0] ad, output logic [31:0] dat);
        psel = 1; penable = 0; pwrite = 0; paddr = ad;
        cyc();
        penable = 1;
        dat = prdata;
        cyc();
        psel = 0; penable = 0;
    endtask

    task automatic pulse_src(input logic [NSRC-1:0] v);
        irq_src = v;
        cyc();
        irq_src = '0;
        repeat (IrqLat + 1) cyc();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        prstn = 0; psel = 0; penable = 0; pwrite = 0; paddr = '0; pstrb = '0; pwdata = '0;
        irq_src = '0;
        model_reset();
        repeat (3) @(posedge pclk);
        #1 prstn = 1;
        for (int i = 0; i < 6; i++) begin
            a = (i == 5) ? 4'hF : 4'(i);
            apb_read(a, d);
            check_eq("rst_rd", d, 32'd0);
        end

        // Level source routing
        apb_write(4'd0, 32'h1, 4'hF);
        apb_write(4'd1, 32'h0, 4'hF);
        irq_src = 16'h0001;
        for (int k = 1; k <= IrqLat; k++) begin
            cyc();
            check_eq("lvl_lat", 32'(irq_o), 32'(k == IrqLat));
        end
        apb_read(4'd3, d);
        check_eq("lvl_claim", d, 32'd1);
        check_eq("busy_irq", 32'(irq_o), 32'd0);
        apb_write(4'd3, 32'd1, 4'hF);
        check_eq("lvl_rearm", 32'(irq_o), 32'd1);

        // Edge priority
        irq_src = '0;
        apb_write(4'd0, 32'h30, 4'hF);
        apb_write(4'd1, 32'h30, 4'hF);
        pulse_src(16'h0030);
        apb_read(4'd2, d);
        check_eq("edge_pend", d, 32'h30);
        apb_read(4'd3, d);
        check_eq("edge_claim5", d, 32'd5);
        apb_write(4'd3, 32'd5, 4'hF);
        apb_read(4'd3, d);
        check_eq("edge_claim6", d, 32'd6);
        apb_write(4'd3, 32'd6, 4'hF);

        // W1C and set/clear collision
        apb_write(4'd1, 32'h4, 4'hF);
        apb_write(4'd0, 32'h4, 4'hF);
        pulse_src(16'h0004);
        apb_read(4'd2, d);
        check_eq("w1c_pre", d, 32'h4);
        irq_src = 16'h0004;
        repeat (Lat - 1) cyc();
        apb_write(4'd2, 32'h4, 4'hF);
        apb_read(4'd2, d);
        check_eq("w1c_coll", d, 32'h4);
        irq_src = '0;
        repeat (3) cyc();
        apb_write(4'd2, 32'h4, 4'hF);
        apb_read(4'd2, d);
        check_eq("w1c_clr", d, 32'h0);

        // Protocol errors while busy
        pulse_src(16'h0004);
        apb_read(4'd3, d);
        check_eq("claim3", d, 32'd3);
        apb_write(4'd3, 32'd2, 4'hF);
        apb_read(4'd4, d);
        check_eq("bad_cmpl", d, 32'h301);
        apb_read(4'd3, d);
        check_eq("claim_busy", d, 32'd0);
        apb_write(4'd3, 32'd3, 4'h0);
        apb_read(4'd4, d);
        check_eq("strb0_cmpl", d, 32'h301);
        apb_write(4'd0, 32'hFFFF, 4'h0);
        apb_read(4'd0, d);
        check_eq("strb0_en", d, 32'h4);

        // Reset mid-claim
        #3 prstn = 0;
        model_reset();
        #1;
        check_eq("rst_irq", 32'(irq_o), 32'd0);
        check_eq("rst_prdata", prdata, 32'd0);
        repeat (2) @(posedge pclk);
        #1 prstn = 1;
        for (int i = 0; i < 6; i++) begin
            a = (i == 5) ? 4'hF : 4'(i);
            apb_read(a, d);
            check_eq("rst2_rd", d, 32'd0);
        end

        // Randomised traffic; every cycle is compared against the model
        for (int it = 0; it < 500; it++) begin
            r = $urandom_range(0, 9);
            a = 4'($urandom);
            if (a > 4'd4 && $urandom_range(0, 3) != 0) a = 4'($urandom_range(0, 4));
            case (r)
                0, 1, 2: begin
                    irq_src = NSRC'($urandom);
                    cyc();
                end
                3, 4, 5: apb_write(a, $urandom, 4'($urandom));
                6, 7:    apb_read(a, d);
                8:       apb_read(4'd3, d);
                default: apb_write(4'd3, ($urandom_range(0, 3) == 0) ? $urandom : 32'(m_cur), 4'hF);
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
